// File: rtl/scoreboard.sv
// ============================================================================
// Module   : scoreboard
// Purpose  : Per-register in-flight write tracker for RAW hazard detection.
//            Optional macro SB_R0_ZERO_EN: register 0 is hardwired zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4,
  parameter int TOT_W  = 8,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic                src0_used,
  input  logic [ADDR_W-1:0]   src0_addr,
  input  logic                src1_used,
  input  logic [ADDR_W-1:0]   src1_addr,
  input  logic                retire_valid,
  input  logic [ADDR_W-1:0]   retire_rt,
  input  logic                flush,
  output logic                stall,
  output logic                issue_ack,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [TOT_W-1:0]    inflight,
  output logic                underflow
);

`ifdef SB_R0_ZERO_EN
  localparam bit c_R0_ZERO = 1'b1;
`else
  localparam bit c_R0_ZERO = 1'b0;
`endif

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic [TOT_W-1:0] r_inflight;
  logic             r_underflow;

  logic w_iss_trk;
  logic w_ret_trk;
  logic w_hazard;
  logic w_full;
  logic w_tot_inc;
  logic w_tot_dec;
  logic w_ret_zero;

  // Register 0 drops out of tracking entirely when hardwired to zero; its
  // counter then never leaves 0, so reads of it can never hazard.
  assign w_iss_trk = !(c_R0_ZERO && (issue_rt == '0));
  assign w_ret_trk = retire_valid && !(c_R0_ZERO && (retire_rt == '0));

  assign w_hazard = (src0_used && (r_cnt[src0_addr] != '0)) ||
                    (src1_used && (r_cnt[src1_addr] != '0));
  assign w_full   = issue_wr && (r_cnt[issue_rt] == '1);

  assign stall     = issue_valid && !flush && (w_hazard || w_full);
  assign issue_ack = issue_valid && !flush && !stall;

  assign w_ret_zero = (r_cnt[retire_rt] == '0);
  assign w_tot_inc  = issue_ack && issue_wr && w_iss_trk;
  assign w_tot_dec  = w_ret_trk && !w_ret_zero;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic w_inc;
      logic w_dec;

      assign w_inc = w_tot_inc && (issue_rt == ADDR_W'(gi));
      assign w_dec = w_tot_dec && (retire_rt == ADDR_W'(gi));

      // Full blocks issue, so an increment can never wrap the counter.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_cnt[gi] <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt[gi] <= r_cnt[gi] + 1'b1;
        end else if (w_dec && !w_inc) begin
          r_cnt[gi] <= r_cnt[gi] - 1'b1;
        end
      end

      assign busy_mask[gi] = |r_cnt[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_inflight <= '0;
    end else if (w_tot_inc && !w_tot_dec && (r_inflight != '1)) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (w_tot_dec && !w_tot_inc && (r_inflight != '0)) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (!flush && w_ret_trk && w_ret_zero) begin
      r_underflow <= 1'b1;
    end
  end

  assign inflight  = r_inflight;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard.sv
// ============================================================================
// Module   : tb_scoreboard
// Purpose  : Directed self-checking bench for scoreboard (CNT_W=2, TOT_W=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scoreboard;

  localparam int c_ADDR_W = 4;
  localparam int c_CNT_W  = 2;
  localparam int c_TOT_W  = 3;
  localparam int c_NREGS  = 2**c_ADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid, issue_wr;
  logic [c_ADDR_W-1:0] issue_rt;
  logic                src0_used, src1_used;
  logic [c_ADDR_W-1:0] src0_addr, src1_addr;
  logic                retire_valid;
  logic [c_ADDR_W-1:0] retire_rt;
  logic                flush;
  logic                stall, issue_ack, underflow;
  logic [c_NREGS-1:0]  busy_mask;
  logic [c_TOT_W-1:0]  inflight;

  int vec_cnt = 0;
  int err_cnt = 0;

  scoreboard #(.ADDR_W(c_ADDR_W), .CNT_W(c_CNT_W), .TOT_W(c_TOT_W)) u_dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rt(issue_rt),
    .src0_used(src0_used), .src0_addr(src0_addr),
    .src1_used(src1_used), .src1_addr(src1_addr),
    .retire_valid(retire_valid), .retire_rt(retire_rt), .flush(flush),
    .stall(stall), .issue_ack(issue_ack), .busy_mask(busy_mask),
    .inflight(inflight), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic wr, input int rt,
                       input logic s0u, input int s0a, input logic s1u, input int s1a,
                       input logic rv, input int rrt, input logic fl);
    issue_valid  = iv;
    issue_wr     = wr;
    issue_rt     = c_ADDR_W'(rt);
    src0_used    = s0u;
    src0_addr    = c_ADDR_W'(s0a);
    src1_used    = s1u;
    src1_addr    = c_ADDR_W'(s1a);
    retire_valid = rv;
    retire_rt    = c_ADDR_W'(rrt);
    flush        = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy_mask, 0);
    check("rst_inflight", inflight, 0);
    check("rst_underflow", underflow, 0);
    check("rst_stall", stall, 0);

    // RAW hazard on r3, retire in the same cycle does not lift it
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    check("iss3_ack", issue_ack, 1);
    tick();
    drive(1, 1, 4, 1, 3, 0, 0, 1, 3, 0);
    check("raw_stall", stall, 1);
    check("raw_ack", issue_ack, 0);
    check("raw_busy", busy_mask, 16'h0008);
    check("raw_inflight", inflight, 1);
    tick();
    drive(1, 1, 4, 1, 3, 0, 0, 0, 0, 0);
    check("raw_clear_stall", stall, 0);
    check("raw_clear_ack", issue_ack, 1);
    tick();
    check("iss4_busy", busy_mask, 16'h0010);
    check("iss4_inflight", inflight, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    tick();
    check("ret4_busy", busy_mask, 0);
    check("ret4_inflight", inflight, 0);

    // counter saturation on r5 (CNT_W=2 -> max 3)
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    check("full_stall", stall, 1);
    check("full_ack", issue_ack, 0);
    tick();
    check("full_inflight", inflight, 3);
    check("full_busy", busy_mask, 16'h0020);
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    check("src1_stall", stall, 1);

    // same-register and different-register issue+retire
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("iss7_inflight", inflight, 4);
    drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    check("same_ack", issue_ack, 1);
    tick();
    check("same_inflight", inflight, 4);
    check("same_busy", busy_mask, 16'h00A0);
    drive(1, 1, 8, 0, 0, 0, 0, 1, 7, 0);
    tick();
    check("diff_inflight", inflight, 4);
    check("diff_busy", busy_mask, 16'h0120);

    // flush beats issue and a would-be underflow retire
    drive(1, 1, 2, 0, 0, 0, 0, 1, 2, 1);
    check("flush_ack", issue_ack, 0);
    check("flush_stall", stall, 0);
    tick();
    idle();
    check("flush_busy", busy_mask, 0);
    check("flush_inflight", inflight, 0);
    check("flush_underflow", underflow, 0);

    // sticky underflow
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    tick();
    idle();
    check("uf_set", underflow, 1);
    check("uf_busy", busy_mask, 0);
    check("uf_inflight", inflight, 0);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    check("uf_hold", underflow, 1);
    check("uf_inflight2", inflight, 1);

    // reset overrides issue and a zero-count retire
    rst = 1'b1;
    drive(1, 1, 1, 0, 0, 0, 0, 1, 2, 0);
    tick();
    rst = 1'b0;
    idle();
    check("rst2_underflow", underflow, 0);
    check("rst2_inflight", inflight, 0);
    check("rst2_busy", busy_mask, 0);

    // register 0 behaviour depends on SB_R0_ZERO_EN
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef SB_R0_ZERO_EN
    check("r0_stall", stall, 0);
    check("r0_busy", busy_mask, 0);
    check("r0_inflight", inflight, 0);
`else
    check("r0_stall", stall, 1);
    check("r0_busy", busy_mask, 16'h0001);
    check("r0_inflight", inflight, 1);
`endif
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;

    // inflight saturation (TOT_W=3 -> max 7)
    for (int r = 1; r <= 8; r++) begin
      drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    check("sat_inflight", inflight, 7);
    check("sat_busy", busy_mask, 16'h01FE);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    idle();
    check("sat_dec", inflight, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 Parameter: ADDR_W, default 4, register-address width; NUM_REGS = 2**ADDR_W tracked registers.
REQ-002 Parameter: CNT_W, default 4, width of each per-register in-flight write counter.
REQ-003 Parameter: TOT_W, default 8, width of the total in-flight write counter.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 issue_valid  in  1  the decode-stage instruction requests issue this cycle.
REQ-007 issue_wr  in  1  the issuing instruction writes a register (low for jumps and stores).
REQ-008 issue_rt  in  ADDR_W  destination register of the issuing instruction.
REQ-009 src0_used, src1_used  in  1 each  the corresponding source operand is read.
REQ-010 src0_addr, src1_addr  in  ADDR_W each  source register addresses.
REQ-011 retire_valid  in  1  writeback stage retires a register-writing instruction.
REQ-012 retire_rt  in  ADDR_W  destination register being retired.
REQ-013 flush  in  1  pipeline flush (taken branch); discards all in-flight writes.
REQ-014 stall  out  1  combinational; issue must hold this cycle.
REQ-015 issue_ack  out  1  combinational; issue accepted this cycle.
REQ-016 busy_mask  out  NUM_REGS  bit i high when counter i is nonzero.
REQ-017 inflight  out  TOT_W  total outstanding register writes.
REQ-018 underflow  out  1  sticky error: retire seen against a zero counter.

Function
REQ-019 hazard = (src0_used & cnt[src0_addr]!=0) | (src1_used & cnt[src1_addr]!=0).
REQ-020 full = issue_wr & cnt[issue_rt] == 2**CNT_W-1; the counter never wraps.
REQ-021 stall = issue_valid & !flush & (hazard | full); issue_ack = issue_valid & !flush & !stall.
REQ-022 Counters and inflight update on the next rising edge; busy_mask and inflight reflect registered state, latency 1 cycle from ack/retire.
REQ-023 On issue_ack & issue_wr: cnt[issue_rt] += 1; inflight += 1.
REQ-024 On retire_valid with cnt[retire_rt]!=0: cnt[retire_rt] -= 1; inflight -= 1.
REQ-025 On retire_valid with cnt[retire_rt]==0: the counter and inflight hold; underflow set to 1 and held until rst.
REQ-026 Issue and retire to the same register in the same cycle: net counter and inflight unchanged; to different registers: both applied.
REQ-027 A retire in the same cycle as an issue whose source is that register does not clear the hazard; stall uses pre-edge counters.
REQ-028 flush has priority: all counters and inflight are 0 next cycle; issue and retire in that cycle are ignored; underflow is not set by a retire in a flush cycle.
REQ-029 inflight saturates at 2**TOT_W-1 and never wraps.

Reset
REQ-030 While rst is high at a rising edge: all counters 0, inflight 0, underflow 0; busy_mask is therefore 0.
REQ-031 rst overrides flush, issue and retire; reset mid-operation discards all outstanding state with no underflow report.
REQ-032 stall and issue_ack are combinational and follow REQ-021 during reset using the cleared state.

Configuration
REQ-033 Macro SB_R0_ZERO_EN defined: register 0 is hardwired zero; issue to it does not count, reads of it never hazard, retire to it is ignored (no underflow), and busy_mask[0] is 0.
REQ-034 SB_R0_ZERO_EN undefined: register 0 is tracked exactly like every other register.

Verification
REQ-035 Issue wr rt=3, next cycle issue src0=3 -> stall=1, issue_ack=0; retire rt=3 -> stall=0 one cycle later.
REQ-036 CNT_W=2: issue rt=5 three times with no retire -> fourth issue stalls; cnt stays 3 and inflight stays 3.
REQ-037 Issue rt=7 and retire rt=7 in the same cycle with cnt[7]=1 -> cnt[7]=1 and inflight unchanged.
REQ-038 Three writes in flight, then flush together with issue_valid -> issue_ack=0; next cycle busy_mask=0 and inflight=0.
REQ-039 Retire rt=9 with cnt[9]=0 -> underflow=1 and stays 1 until rst; counter stays 0.
REQ-040 With SB_R0_ZERO_EN: issue rt=0, then src0=0 -> no stall and busy_mask[0]=0; without the macro -> stall=1.
